// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package hazard_pkg;

   localparam int REG_FIELD_W_DEF = 5;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      BUSY = 1'b1
   } hz_state_e;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-register fields in, hazard controls out; master = pipeline, slave = controller.
interface pipeline_hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int REG_FIELD_W = REG_FIELD_W_DEF,
   parameter int CNT_W       = 32
);
   logic [REG_FIELD_W-1:0] rs1_IFID, rs2_IFID;
   logic [REG_FIELD_W-1:0] rs1_IDEX, rs2_IDEX, rd_IDEX;
   logic                   reg_wr_en_IDEX, is_load_IDEX, mc_op_IDEX;
   logic [REG_FIELD_W-1:0] rd_EXMEM, rd_MEMWB;
   logic                   reg_wr_en_EXMEM, reg_wr_en_MEMWB;
   logic                   pc_sel_EXIF;
   logic                   mc_done;

   logic [1:0]             fwd_a_sel, fwd_b_sel;
   logic                   stall_IF, stall_ID, flush_IFID;
   logic                   bubble_IDEX, hold_IDEX, bubble_EXMEM;
   logic                   mc_start, mc_err;
   logic [CNT_W-1:0]       stall_cnt, flush_cnt;

   modport master (
      output rs1_IFID, rs2_IFID, rs1_IDEX, rs2_IDEX, rd_IDEX,
             reg_wr_en_IDEX, is_load_IDEX, mc_op_IDEX,
             rd_EXMEM, rd_MEMWB, reg_wr_en_EXMEM, reg_wr_en_MEMWB,
             pc_sel_EXIF, mc_done,
      input  fwd_a_sel, fwd_b_sel, stall_IF, stall_ID, flush_IFID,
             bubble_IDEX, hold_IDEX, bubble_EXMEM, mc_start, mc_err,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_IFID, rs2_IFID, rs1_IDEX, rs2_IDEX, rd_IDEX,
             reg_wr_en_IDEX, is_load_IDEX, mc_op_IDEX,
             rd_EXMEM, rd_MEMWB, reg_wr_en_EXMEM, reg_wr_en_MEMWB,
             pc_sel_EXIF, mc_done,
      output fwd_a_sel, fwd_b_sel, stall_IF, stall_ID, flush_IFID,
             bubble_IDEX, hold_IDEX, bubble_EXMEM, mc_start, mc_err,
             stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Per-operand forwarding select; the younger EXMEM result wins over MEMWB.
module fwd_unit
   import hazard_pkg::*;
#(
   parameter int REG_FIELD_W = REG_FIELD_W_DEF
) (
   input  logic [REG_FIELD_W-1:0] rs,
   input  logic [REG_FIELD_W-1:0] rd_EXMEM,
   input  logic                   reg_wr_en_EXMEM,
   input  logic [REG_FIELD_W-1:0] rd_MEMWB,
   input  logic                   reg_wr_en_MEMWB,
   output logic [1:0]             sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_wr_en_EXMEM && (rd_EXMEM != '0) && (rd_EXMEM == rs))
         sel = FWD_EXMEM;
      else if (reg_wr_en_MEMWB && (rd_MEMWB != '0) && (rd_MEMWB == rs))
         sel = FWD_MEMWB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use/branch stalls and mul/div sequencing.
// state | meaning
// RUN   | normal issue; resolves mc start, branch flush, load-use stall
// BUSY  | multi-cycle unit running; pipeline held until done or watchdog
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_FIELD_W = REG_FIELD_W_DEF,
   parameter int MC_TIMEOUT  = 64,
   parameter int CNT_W       = 32
) (
   input logic                 clk,
   input logic                 reset,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam logic [0:0] ST_RUN  = RUN;
   localparam logic [0:0] ST_BUSY = BUSY;
   localparam int         WD_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

   logic [0:0]       state_q, state_d;
   logic [WD_W-1:0]  wd_q;
   logic             mc_err_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic [1:0] fwd_a, fwd_b;
   logic       load_use, wd_expired, err_set;
   logic       stall_IF, stall_ID, flush_IFID, bubble_IDEX;
   logic       hold_IDEX, bubble_EXMEM, mc_start;

   fwd_unit #(.REG_FIELD_W(REG_FIELD_W)) u_fwd_a (
      .rs              (bus.rs1_IDEX),
      .rd_EXMEM        (bus.rd_EXMEM),
      .reg_wr_en_EXMEM (bus.reg_wr_en_EXMEM),
      .rd_MEMWB        (bus.rd_MEMWB),
      .reg_wr_en_MEMWB (bus.reg_wr_en_MEMWB),
      .sel             (fwd_a)
   );

   fwd_unit #(.REG_FIELD_W(REG_FIELD_W)) u_fwd_b (
      .rs              (bus.rs2_IDEX),
      .rd_EXMEM        (bus.rd_EXMEM),
      .reg_wr_en_EXMEM (bus.reg_wr_en_EXMEM),
      .rd_MEMWB        (bus.rd_MEMWB),
      .reg_wr_en_MEMWB (bus.reg_wr_en_MEMWB),
      .sel             (fwd_b)
   );

   assign load_use = bus.is_load_IDEX && bus.reg_wr_en_IDEX && (bus.rd_IDEX != '0) &&
                     ((bus.rd_IDEX == bus.rs1_IFID) || (bus.rd_IDEX == bus.rs2_IFID));

   assign wd_expired = (wd_q == WD_LAST);

   always_comb begin
      state_d      = state_q;
      mc_start     = 1'b0;
      stall_IF     = 1'b0;
      stall_ID     = 1'b0;
      flush_IFID   = 1'b0;
      bubble_IDEX  = 1'b0;
      hold_IDEX    = 1'b0;
      bubble_EXMEM = 1'b0;
      err_set      = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.mc_op_IDEX) begin
               // A resolved branch alongside an mc op cannot both be honoured.
               mc_start     = 1'b1;
               stall_IF     = 1'b1;
               stall_ID     = 1'b1;
               hold_IDEX    = 1'b1;
               bubble_EXMEM = 1'b1;
               err_set      = bus.pc_sel_EXIF;
               state_d      = ST_BUSY;
            end else if (bus.pc_sel_EXIF) begin
               flush_IFID  = 1'b1;
               bubble_IDEX = 1'b1;
            end else if (load_use) begin
               stall_IF    = 1'b1;
               stall_ID    = 1'b1;
               bubble_IDEX = 1'b1;
            end
         end
         ST_BUSY: begin
            if (bus.mc_done || wd_expired) begin
               err_set = !bus.mc_done;
               state_d = ST_RUN;
            end else begin
               stall_IF     = 1'b1;
               stall_ID     = 1'b1;
               hold_IDEX    = 1'b1;
               bubble_EXMEM = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         wd_q        <= '0;
         mc_err_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= (state_q == ST_BUSY) ? wd_q + WD_W'(1) : '0;
         if (err_set)
            mc_err_q <= 1'b1;
         if (stall_IF && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_IFID && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   // Controls are combinational, so they are masked explicitly while reset is high.
   assign bus.fwd_a_sel    = reset ? FWD_RF : fwd_a;
   assign bus.fwd_b_sel    = reset ? FWD_RF : fwd_b;
   assign bus.stall_IF     = stall_IF     & ~reset;
   assign bus.stall_ID     = stall_ID     & ~reset;
   assign bus.flush_IFID   = flush_IFID   & ~reset;
   assign bus.bubble_IDEX  = bubble_IDEX  & ~reset;
   assign bus.hold_IDEX    = hold_IDEX    & ~reset;
   assign bus.bubble_EXMEM = bubble_EXMEM & ~reset;
   assign bus.mc_start     = mc_start     & ~reset;
   assign bus.mc_err       = mc_err_q;
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance runs with a short watchdog.
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   pipeline_hazard_ctrl_if #(.REG_FIELD_W(5), .CNT_W(32)) bus ();
   pipeline_hazard_ctrl_if #(.REG_FIELD_W(5), .CNT_W(32)) bus_wd ();

   pipeline_hazard_ctrl #(.REG_FIELD_W(5), .MC_TIMEOUT(64), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   pipeline_hazard_ctrl #(.REG_FIELD_W(5), .MC_TIMEOUT(8), .CNT_W(32)) dut_wd (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_wd)
   );

   assign bus_wd.rs1_IFID        = bus.rs1_IFID;
   assign bus_wd.rs2_IFID        = bus.rs2_IFID;
   assign bus_wd.rs1_IDEX        = bus.rs1_IDEX;
   assign bus_wd.rs2_IDEX        = bus.rs2_IDEX;
   assign bus_wd.rd_IDEX         = bus.rd_IDEX;
   assign bus_wd.reg_wr_en_IDEX  = bus.reg_wr_en_IDEX;
   assign bus_wd.is_load_IDEX    = bus.is_load_IDEX;
   assign bus_wd.mc_op_IDEX      = bus.mc_op_IDEX;
   assign bus_wd.rd_EXMEM        = bus.rd_EXMEM;
   assign bus_wd.rd_MEMWB        = bus.rd_MEMWB;
   assign bus_wd.reg_wr_en_EXMEM = bus.reg_wr_en_EXMEM;
   assign bus_wd.reg_wr_en_MEMWB = bus.reg_wr_en_MEMWB;
   assign bus_wd.pc_sel_EXIF     = bus.pc_sel_EXIF;
   assign bus_wd.mc_done         = bus.mc_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.rs1_IFID        = '0;
      bus.rs2_IFID        = '0;
      bus.rs1_IDEX        = '0;
      bus.rs2_IDEX        = '0;
      bus.rd_IDEX         = '0;
      bus.reg_wr_en_IDEX  = 1'b0;
      bus.is_load_IDEX    = 1'b0;
      bus.mc_op_IDEX      = 1'b0;
      bus.rd_EXMEM        = '0;
      bus.rd_MEMWB        = '0;
      bus.reg_wr_en_EXMEM = 1'b0;
      bus.reg_wr_en_MEMWB = 1'b0;
      bus.pc_sel_EXIF     = 1'b0;
      bus.mc_done         = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed simulation still running expected finished");
      $fatal(1, "global timeout");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      clear_inputs();

      // Outputs masked while in reset even with active hazard inputs
      bus.rd_EXMEM = 5'd5; bus.reg_wr_en_EXMEM = 1'b1; bus.rs1_IDEX = 5'd5;
      bus.pc_sel_EXIF = 1'b1; bus.mc_op_IDEX = 1'b1;
      #2;
      chk("rst_fwd_a",    bus.fwd_a_sel, 2'b00);
      chk("rst_mc_start", bus.mc_start, 1'b0);
      chk("rst_flush",    bus.flush_IFID, 1'b0);
      chk("rst_stall_if", bus.stall_IF, 1'b0);
      tick(); tick();
      clear_inputs();
      reset = 1'b0;
      #2;
      chk("init_stall_cnt", bus.stall_cnt, 32'd0);
      chk("init_flush_cnt", bus.flush_cnt, 32'd0);
      chk("init_mc_err",    bus.mc_err, 1'b0);
      chk("init_state",     dut.state_q, 1'b0);

      // Forwarding vectors
      bus.rd_EXMEM = 5'd5; bus.reg_wr_en_EXMEM = 1'b1;
      bus.rd_MEMWB = 5'd5; bus.reg_wr_en_MEMWB = 1'b1;
      bus.rs1_IDEX = 5'd5; bus.rs2_IDEX = 5'd0;
      #1;
      chk("fwd_both_a", bus.fwd_a_sel, 2'b01);
      chk("fwd_both_b", bus.fwd_b_sel, 2'b00);
      bus.rd_EXMEM = 5'd0; bus.rd_MEMWB = 5'd0; bus.rs1_IDEX = 5'd0;
      #1;
      chk("fwd_x0_a", bus.fwd_a_sel, 2'b00);
      bus.rd_EXMEM = 5'd3; bus.rd_MEMWB = 5'd9; bus.rs1_IDEX = 5'd9; bus.rs2_IDEX = 5'd3;
      #1;
      chk("fwd_mix_a", bus.fwd_a_sel, 2'b10);
      chk("fwd_mix_b", bus.fwd_b_sel, 2'b01);
      bus.rd_EXMEM = 5'd9; bus.reg_wr_en_EXMEM = 1'b0;
      #1;
      chk("fwd_exmem_off_a", bus.fwd_a_sel, 2'b10);
      bus.reg_wr_en_MEMWB = 1'b0;
      #1;
      chk("fwd_none_a", bus.fwd_a_sel, 2'b00);
      tick();
      clear_inputs();

      // Load-use stall
      bus.is_load_IDEX = 1'b1; bus.reg_wr_en_IDEX = 1'b1; bus.rd_IDEX = 5'd7; bus.rs2_IFID = 5'd7;
      #2;
      chk("lu_stall_if",  bus.stall_IF, 1'b1);
      chk("lu_stall_id",  bus.stall_ID, 1'b1);
      chk("lu_bubble",    bus.bubble_IDEX, 1'b1);
      chk("lu_hold_idex", bus.hold_IDEX, 1'b0);
      chk("lu_flush",     bus.flush_IFID, 1'b0);
      tick();
      bus.is_load_IDEX = 1'b0;
      #2;
      chk("lu_stall_cnt", bus.stall_cnt, 32'd1);
      chk("lu_next_free", bus.stall_IF, 1'b0);
      tick();
      bus.is_load_IDEX = 1'b1; bus.rd_IDEX = 5'd0; bus.rs2_IFID = 5'd0;
      #2;
      chk("lu_rd0_stall", bus.stall_IF, 1'b0);
      tick();
      clear_inputs();
      #2;
      chk("lu_rd0_cnt", bus.stall_cnt, 32'd1);

      // Branch flush beats load-use
      bus.is_load_IDEX = 1'b1; bus.reg_wr_en_IDEX = 1'b1; bus.rd_IDEX = 5'd7; bus.rs1_IFID = 5'd7;
      bus.pc_sel_EXIF = 1'b1;
      #1;
      chk("br_flush",    bus.flush_IFID, 1'b1);
      chk("br_bubble",   bus.bubble_IDEX, 1'b1);
      chk("br_stall_if", bus.stall_IF, 1'b0);
      chk("br_stall_id", bus.stall_ID, 1'b0);
      tick();
      clear_inputs();
      #2;
      chk("br_flush_cnt", bus.flush_cnt, 32'd1);
      chk("br_stall_cnt", bus.stall_cnt, 32'd1);
      tick();

      // Multi-cycle op, done after 10 cycles
      bus.mc_op_IDEX = 1'b1;
      #2;
      chk("mc_start0",   bus.mc_start, 1'b1);
      chk("mc_stall0",   bus.stall_IF, 1'b1);
      chk("mc_hold0",    bus.hold_IDEX, 1'b1);
      chk("mc_bub_ex0",  bus.bubble_EXMEM, 1'b1);
      chk("mc_bub_id0",  bus.bubble_IDEX, 1'b0);
      tick();
      for (int k = 1; k < 10; k++) begin
         #2;
         chk("mc_busy_start", bus.mc_start, 1'b0);
         chk("mc_busy_stall", bus.stall_IF, 1'b1);
         chk("mc_busy_hold",  bus.hold_IDEX, 1'b1);
         tick();
      end
      bus.mc_done = 1'b1;
      #2;
      chk("mc_done_stall", bus.stall_IF, 1'b0);
      chk("mc_done_hold",  bus.hold_IDEX, 1'b0);
      chk("mc_done_bubex", bus.bubble_EXMEM, 1'b0);
      chk("mc_done_start", bus.mc_start, 1'b0);
      tick();
      bus.mc_done = 1'b0;
      #2;
      chk("mc_state_run",  dut.state_q, 1'b0);
      chk("mc_stall_cnt",  bus.stall_cnt, 32'd11);
      chk("b2b_start",     bus.mc_start, 1'b1);
      tick();
      bus.mc_done = 1'b1;
      #2;
      chk("b2b_done_stall", bus.stall_IF, 1'b0);
      tick();
      bus.mc_done = 1'b0; bus.mc_op_IDEX = 1'b0;
      #2;
      chk("b2b_stall_cnt", bus.stall_cnt, 32'd12);
      chk("b2b_mc_err",    bus.mc_err, 1'b0);

      // Illegal mc op plus branch
      bus.mc_op_IDEX = 1'b1; bus.pc_sel_EXIF = 1'b1;
      #2;
      chk("ill_start",  bus.mc_start, 1'b1);
      chk("ill_flush",  bus.flush_IFID, 1'b0);
      chk("ill_bubble", bus.bubble_IDEX, 1'b0);
      tick();
      bus.pc_sel_EXIF = 1'b0; bus.mc_done = 1'b1;
      #2;
      chk("ill_err", bus.mc_err, 1'b1);
      tick();
      bus.mc_done = 1'b0; bus.mc_op_IDEX = 1'b0;
      #2;
      chk("ill_err_sticky", bus.mc_err, 1'b1);
      chk("ill_flush_cnt",  bus.flush_cnt, 32'd1);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk("rst_clears_err", bus.mc_err, 1'b0);
      tick();

      // Watchdog abort on the MC_TIMEOUT=8 instance
      bus.mc_op_IDEX = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #2;
         chk("wd_hold", bus_wd.stall_IF, 1'b1);
         tick();
      end
      #2;
      chk("wd_release", bus_wd.stall_IF, 1'b0);
      chk("wd_err_pre", bus_wd.mc_err, 1'b0);
      tick();
      bus.mc_op_IDEX = 1'b0;
      #2;
      chk("wd_err",       bus_wd.mc_err, 1'b1);
      chk("wd_stall_cnt", bus_wd.stall_cnt, 32'd8);
      chk("wd_state_run", dut_wd.state_q, 1'b0);
      tick(); tick();
      bus.rd_EXMEM = 5'd5; bus.reg_wr_en_EXMEM = 1'b1; bus.rs1_IDEX = 5'd5;
      #2;
      chk("wd_err_sticky",  bus_wd.mc_err, 1'b1);
      chk("main_busy_hold", bus.stall_IF, 1'b1);
      chk("hold_fwd_a",     bus.fwd_a_sel, 2'b01);

      // Asynchronous reset mid-BUSY
      reset = 1'b1;
      #1;
      chk("arst_stall",  bus.stall_IF, 1'b0);
      chk("arst_hold",   bus.hold_IDEX, 1'b0);
      chk("arst_bubex",  bus.bubble_EXMEM, 1'b0);
      chk("arst_fwd_a",  bus.fwd_a_sel, 2'b00);
      chk("arst_cnt",    bus.stall_cnt, 32'd0);
      chk("arst_state",  dut.state_q, 1'b0);
      chk("arst_wd_err", bus_wd.mc_err, 1'b0);
      tick();
      clear_inputs();
      reset = 1'b0;
      bus.mc_done = 1'b1;
      #2;
      chk("stray_start", bus.mc_start, 1'b0);
      chk("stray_stall", bus.stall_IF, 1'b0);
      tick();
      bus.mc_done = 1'b0;
      #2;
      chk("stray_state", dut.state_q, 1'b0);
      chk("stray_cnt",   bus.stall_cnt, 32'd0);
      chk("stray_err",   bus.mc_err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
